aqalu_result_logger: RTL
========================

# aqalu_result_logger

Hardware result logger for on-chip AQALU verification. It captures AQALU operand/opcode/result samples through a valid/ready handshake and buffers them in a FIFO. Each sample is stamped with an elapsed-seconds count and serialized as a 5-byte checksummed frame onto a byte stream for the Python vector checker on the host. It sits between the AQALU outputs and the host-link byte transmitter.

## Interface
- CLK_PER_SEC, 10_000_000: clock cycles per timestamp second (10 MHz system clock).
- DEPTH, 8: FIFO depth in samples; power of 2, ≥2.
- clock  in  1  system clock; all logic is on the rising edge.
- reset  in  1  synchronous, active-low reset.
- sample_valid  in  1  sample present on A/B/Opcode/Output.
- sample_ready  out  1  logger can accept a sample.
- A  in  2  ALU operand A.
- B  in  2  ALU operand B.
- Opcode  in  4  ALU opcode.
- Output  in  8  ALU result.
- tx_data  out  8  frame byte.
- tx_valid  out  1  tx_data valid.
- tx_ready  in  1  downstream accepts the byte.
- seconds  out  8  current elapsed-seconds count.
- fifo_count  out  $clog2(DEPTH)+1  entries currently queued.

## Operation
- **Timestamp**
  - tick counter runs 0..CLK_PER_SEC-1. On the terminal count it returns to 0 and `seconds` increments, wrapping 255→0.
- **Capture**
  - sample_ready = (fifo_count < DEPTH), combinational from the registered count.
  - Accept = sample_valid & sample_ready.
  - An accept with Opcode != 4'hF pushes {A,B,Opcode,Output,seconds} (24 bits) into the FIFO.
  - An accept with Opcode == 4'hF completes the handshake but is discarded; nothing is enqueued.
- **FIFO**
  - Circular buffer with wrapping read/write pointers.
  - Push and pop in the same cycle leaves the count unchanged.
  - When full, no push occurs even if a pop happens in the same cycle.
- **Frame** (5 bytes, in this order):
  - 0xA5 (sync)
  - {A,B,Opcode}
  - Output
  - timestamp
  - XOR of bytes 1–3
- **Serializer FSM** (states IDLE, SYNC, HDR, RES, TIME, CSUM):
  - IDLE: if fifo_count != 0, pop the head into the frame register and go to SYNC.
  - SYNC through CSUM: tx_valid=1, tx_data = that state's byte. On tx_valid & tx_ready, advance to the next state; CSUM goes to IDLE.
  - tx_data stays stable while tx_valid=1 and tx_ready=0.

## Timing
- **Reset values** (reset=0 at a rising edge):
  - sample_ready=0 during reset, 1 the cycle after release.
  - tx_valid=0, tx_data=8'h00, seconds=0, tick=0, fifo_count=0, FSM=IDLE.
- **Reset mid-frame**: the frame is aborted and all queued samples are lost. tx_valid is low after that edge.
- **Latency**: with the FIFO empty and the FSM in IDLE, a sample accepted at edge N gives fifo_count=1 after N. The pop happens at N+1. tx_valid=1 with 0xA5 after N+1.
- **Throughput**: with tx_ready held high, one frame takes 6 cycles (5 bytes plus 1 IDLE bubble).
- **Timestamp value**: the `seconds` value sampled at the accept edge. The increment on that same edge is not included.
- **Simultaneous events**:
  - A pop in IDLE frees a slot the following cycle. sample_ready reflects the registered count only.
  - An Opcode-4'hF accept while full does not occur, because sample_ready=0 gates the handshake.

## Test plan
- **Single sample**: reset, then A=2'b01, B=2'b10, Opcode=4'h3, Output=8'h03 with tx_ready=1 → bytes A5, 63, 03, 00, 60; tx_valid first high 2 cycles after accept; fifo_count returns to 0.
- **Back-pressure**: the same sample with tx_ready=0 for 10 cycles, then 1 → tx_data holds A5 with tx_valid=1 throughout the stall; the full frame follows, unchanged.
- **Full FIFO**: tx_ready=0, push 9 distinct samples with sample_valid held high → first frame popped, 8 remain queued after the accepts (fifo_count=8), sample_ready=0; the 9th is accepted only after a pop; release tx_ready → frames emerge in push order, checksums correct.
- **Opcode filter**: interleave Opcode=4'hF samples with valid ones → handshakes complete, no frames for the 4'hF samples, fifo_count unaffected.
- **Timestamp**: CLK_PER_SEC=4, accept samples at cycles 3 and 9 after reset release → timestamp bytes 00 and 02; run 1024+ cycles → seconds wraps 255→0.
- **Reset mid-frame**: assert reset after the HDR byte is sent with 3 samples queued → tx_valid=0 next cycle, fifo_count=0; a new sample after release produces a clean frame starting with A5.

Source files
------------

// File: rtl/aqalu_result_logger_if.sv
// aqalu_result_logger_if: sample capture and byte-stream bundle.
// slave is the logger side; master is the AQALU/host-link side.
interface aqalu_result_logger_if #(
  parameter int DEPTH = 8
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          sample_valid;
  logic          sample_ready;
  logic [1:0]    A;
  logic [1:0]    B;
  logic [3:0]    Opcode;
  logic [7:0]    Output;
  logic [7:0]    tx_data;
  logic          tx_valid;
  logic          tx_ready;
  logic [7:0]    seconds;
  logic [CW-1:0] fifo_count;

  modport slave (
    input  sample_valid,
    input  A,
    input  B,
    input  Opcode,
    input  Output,
    input  tx_ready,
    output sample_ready,
    output tx_data,
    output tx_valid,
    output seconds,
    output fifo_count
  );

  modport master (
    output sample_valid,
    output A,
    output B,
    output Opcode,
    output Output,
    output tx_ready,
    input  sample_ready,
    input  tx_data,
    input  tx_valid,
    input  seconds,
    input  fifo_count
  );
endinterface

// File: rtl/aqalu_result_logger.sv
// aqalu_result_logger: queues AQALU samples with a seconds stamp
// and streams each one as a 5-byte checksummed frame.
module aqalu_result_logger #(
  parameter int CLK_PER_SEC = 10_000_000,
  parameter int DEPTH       = 8
) (
  input logic                  clock,
  input logic                  reset,
  aqalu_result_logger_if.slave bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int TW =
    (CLK_PER_SEC > 1) ? $clog2(CLK_PER_SEC) : 1;

  localparam logic [TW-1:0] TICK_LAST =
    TW'(CLK_PER_SEC - 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  localparam logic [7:0] SYNC_BYTE = 8'hA5;
  localparam logic [3:0] OP_DROP = 4'hF;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SYNC,
    S_HDR,
    S_RES,
    S_TIME,
    S_CSUM
  } state_t;

  logic [TW-1:0] tick_q;
  logic [TW-1:0] tick_d;
  logic [7:0]    sec_q;
  logic [7:0]    sec_d;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [23:0]   mem_q [DEPTH];
  logic [23:0]   frame_q;
  state_t        state_q;
  logic          tx_valid_q;
  logic [7:0]    tx_data_q;

  logic          ready;
  logic          accept;
  logic          push;
  logic          pop;
  logic [23:0]   entry;
  logic [7:0]    csum;

  // Ready is held low while reset is asserted.
  assign ready  = reset & (cnt_q < FULL);
  assign accept = bus.sample_valid & ready;
  assign push   = accept & (bus.Opcode != OP_DROP);
  assign pop    = (state_q == S_IDLE) & (cnt_q != '0);
  assign entry  = {bus.A, bus.B, bus.Opcode,
                   bus.Output, sec_q};
  assign csum   = frame_q[23:16] ^ frame_q[15:8]
                ^ frame_q[7:0];

  assign bus.sample_ready = ready;
  assign bus.tx_valid     = tx_valid_q;
  assign bus.tx_data      = tx_data_q;
  assign bus.seconds      = sec_q;
  assign bus.fifo_count   = cnt_q;

  // Next tick/seconds value and next queue occupancy.
  always_comb begin
    tick_d = tick_q + 1'b1;
    sec_d  = sec_q;
    if (tick_q == TICK_LAST) begin
      tick_d = '0;
      sec_d  = sec_q + 8'd1;
    end
    cnt_d = cnt_q;
    unique case (1'b1)
      push & ~pop: cnt_d = cnt_q + 1'b1;
      pop & ~push: cnt_d = cnt_q - 1'b1;
      default:     cnt_d = cnt_q;
    endcase
  end

  // Elapsed-seconds timebase; seconds wraps naturally at 8 bits.
  always_ff @(posedge clock) begin
    if (!reset) begin
      tick_q <= '0;
      sec_q  <= '0;
    end else begin
      tick_q <= tick_d;
      sec_q  <= sec_d;
    end
  end

  // Circular-buffer pointers and occupancy.
  always_ff @(posedge clock) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      cnt_q <= cnt_d;
    end
  end

  // Sample storage; the pointers alone define which slots are live.
  always_ff @(posedge clock) begin
    if (push) mem_q[wr_ptr_q] <= entry;
  end

  // Frame serializer: each state presents one registered byte.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      frame_q    <= '0;
      tx_valid_q <= 1'b0;
      tx_data_q  <= 8'h00;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (pop) begin
            frame_q    <= mem_q[rd_ptr_q];
            state_q    <= S_SYNC;
            tx_valid_q <= 1'b1;
            tx_data_q  <= SYNC_BYTE;
          end
        end
        S_SYNC: begin
          if (bus.tx_ready) begin
            state_q   <= S_HDR;
            tx_data_q <= frame_q[23:16];
          end
        end
        S_HDR: begin
          if (bus.tx_ready) begin
            state_q   <= S_RES;
            tx_data_q <= frame_q[15:8];
          end
        end
        S_RES: begin
          if (bus.tx_ready) begin
            state_q   <= S_TIME;
            tx_data_q <= frame_q[7:0];
          end
        end
        S_TIME: begin
          if (bus.tx_ready) begin
            state_q   <= S_CSUM;
            tx_data_q <= csum;
          end
        end
        S_CSUM: begin
          if (bus.tx_ready) begin
            state_q    <= S_IDLE;
            tx_valid_q <= 1'b0;
            tx_data_q  <= 8'h00;
          end
        end
        default: begin
          state_q    <= S_IDLE;
          tx_valid_q <= 1'b0;
          tx_data_q  <= 8'h00;
        end
      endcase
    end
  end

endmodule
